// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: opcodes, ALU/immediate enums, control bundle and decode helpers for the RV32I pipeline
package rv_pipe_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_e;
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;
  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    mem_to_reg;
    logic    branch;
    logic    jump;
    logic    illegal;
  } ctrl_t;
  // SUB only exists for R-type; OP-IMM funct7 bit only selects SRAI
  function automatic alu_op_e alu_decode(logic [2:0] f3, logic f7b5, logic is_r);
    return f3 == 3'd0 ? ((is_r & f7b5) ? ALU_SUB : ALU_ADD) :
           f3 == 3'd1 ? ALU_SLL :
           f3 == 3'd2 ? ALU_SLT :
           f3 == 3'd3 ? ALU_SLTU :
           f3 == 3'd4 ? ALU_XOR :
           f3 == 3'd5 ? (f7b5 ? ALU_SRA : ALU_SRL) :
           f3 == 3'd6 ? ALU_OR : ALU_AND;
  endfunction
  function automatic ctrl_t decode(logic [31:0] instr);
    ctrl_t c;
    c = '0;
    case (instr[6:0])
      OP_R: begin
        c.alu_op    = alu_decode(instr[14:12], instr[30], 1'b1);
        c.reg_write = 1'b1;
      end
      OP_IMM: begin
        c.alu_op    = alu_decode(instr[14:12], instr[30], 1'b0);
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
      end
      OP_LOAD: begin
        c.alu_src    = 1'b1;
        c.mem_read   = 1'b1;
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      OP_STORE: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      OP_BRANCH: begin
        c.alu_op = ALU_SUB;
        c.branch = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.jump      = 1'b1;
      end
      OP_LUI: begin
        c.alu_op    = ALU_PASS_B;
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
      end
      default: begin
        c.alu_src = 1'b1;
        c.illegal = 1'b1;
      end
    endcase
    c.reg_write = c.reg_write & (instr[11:7] != 5'd0);
    return c;
  endfunction
  function automatic imm_type_e imm_type(logic [6:0] op);
    return (op == OP_IMM || op == OP_LOAD || op == OP_JALR) ? IMM_I :
           op == OP_STORE ? IMM_S :
           op == OP_BRANCH ? IMM_B :
           (op == OP_LUI || op == OP_AUIPC) ? IMM_U :
           op == OP_JAL ? IMM_J : IMM_NONE;
  endfunction
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: IF/ID inputs, register-file port, pipeline control and ID/EX outputs
interface id_ex_stage_if #(parameter int XLEN = 32, parameter int NREG_BITS = 5);
  import rv_pipe_pkg::*;
  logic                 if_id_valid;
  logic [XLEN-1:0]      if_id_pc;
  logic [31:0]          if_id_instr;
  logic [NREG_BITS-1:0] rs1_addr;
  logic [NREG_BITS-1:0] rs2_addr;
  logic [XLEN-1:0]      rs1_data;
  logic [XLEN-1:0]      rs2_data;
  logic                 flush;
  logic                 hold;
  logic                 stall_if;
  logic                 ex_valid;
  logic [XLEN-1:0]      ex_pc;
  logic [XLEN-1:0]      ex_rs1_data;
  logic [XLEN-1:0]      ex_rs2_data;
  logic [XLEN-1:0]      ex_imm;
  logic [NREG_BITS-1:0] ex_rd;
  logic [NREG_BITS-1:0] ex_rs1;
  logic [NREG_BITS-1:0] ex_rs2;
  alu_op_e              ex_alu_op;
  logic                 ex_alu_src;
  logic                 ex_mem_read;
  logic                 ex_mem_write;
  logic                 ex_reg_write;
  logic                 ex_mem_to_reg;
  logic                 ex_branch;
  logic                 ex_jump;
  logic                 ex_illegal;
  modport master (
    output if_id_valid, if_id_pc, if_id_instr, rs1_data, rs2_data, flush, hold,
    input  rs1_addr, rs2_addr, stall_if, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rd, ex_rs1, ex_rs2, ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write,
           ex_reg_write, ex_mem_to_reg, ex_branch, ex_jump, ex_illegal
  );
  modport slave (
    input  if_id_valid, if_id_pc, if_id_instr, rs1_data, rs2_data, flush, hold,
    output rs1_addr, rs2_addr, stall_if, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rd, ex_rs1, ex_rs2, ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write,
           ex_reg_write, ex_mem_to_reg, ex_branch, ex_jump, ex_illegal
  );
endinterface

// File: rtl/rv_imm_gen.sv
// rv_imm_gen: combinational I/S/B/U/J immediate extraction, sign-extended to XLEN
module rv_imm_gen import rv_pipe_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr_i,
  input  imm_type_e       imm_type_i,
  output logic [XLEN-1:0] imm_o
);
  logic [31:0] imm32;
  always_comb
    imm32 = imm_type_i == IMM_I ? {{20{instr_i[31]}}, instr_i[31:20]} :
            imm_type_i == IMM_S ? {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]} :
            imm_type_i == IMM_B ? {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0} :
            imm_type_i == IMM_U ? {instr_i[31:12], 12'd0} :
            imm_type_i == IMM_J ? {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0} :
            32'd0;
  assign imm_o = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32I decode back half + ID/EX register with load-use bubble, flush and hold.
// Define ID_EX_PERF_CNT_EN to add bubble/flush performance counters.
module id_ex_stage import rv_pipe_pkg::*; #(
  parameter int XLEN      = 32,
  parameter int NREG_BITS = 5
) (
  input  logic          clock,
  input  logic          reset,
  id_ex_stage_if.slave  bus
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]   perf_bubble_cnt,
  output logic [31:0]   perf_flush_cnt
`endif
);
  logic [31:0]          instr;
  logic [6:0]           op;
  ctrl_t                ctrl_dec, ctrl_q, ctrl_d;
  logic [XLEN-1:0]      imm;
  logic                 valid_q, valid_d;
  logic [XLEN-1:0]      pc_q, pc_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
  logic [NREG_BITS-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic                 rs1_used, rs2_used, hazard;
  assign instr        = bus.if_id_instr;
  assign op           = instr[6:0];
  assign ctrl_dec     = decode(instr);
  assign bus.rs1_addr = NREG_BITS'(instr[19:15]);
  assign bus.rs2_addr = NREG_BITS'(instr[24:20]);
  rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_i    (instr[31:7]),
    .imm_type_i (imm_type(op)),
    .imm_o      (imm)
  );
  assign rs1_used = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  assign rs2_used = op == OP_R || op == OP_STORE || op == OP_BRANCH;
  // rd != 0 keeps x0 out of hazard detection
  assign hazard = valid_q & ctrl_q.mem_read & (rd_q != '0) & bus.if_id_valid &
                  ((rs1_used & (rd_q == bus.rs1_addr)) | (rs2_used & (rd_q == bus.rs2_addr)));
  assign bus.stall_if = reset & ~bus.flush & (bus.hold | hazard);
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rd_d       = rd_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    ctrl_d     = ctrl_q;
    if (bus.flush || (!bus.hold && hazard)) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (!bus.hold) begin
      valid_d    = bus.if_id_valid;
      pc_d       = bus.if_id_pc;
      rs1_data_d = bus.rs1_data;
      rs2_data_d = bus.rs2_data;
      imm_d      = imm;
      rd_d       = NREG_BITS'(instr[11:7]);
      rs1_d      = bus.rs1_addr;
      rs2_d      = bus.rs2_addr;
      ctrl_d     = bus.if_id_valid ? ctrl_dec : '0;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      ctrl_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rd_q       <= rd_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      ctrl_q     <= ctrl_d;
    end
  end
  assign bus.ex_valid      = valid_q;
  assign bus.ex_pc         = pc_q;
  assign bus.ex_rs1_data   = rs1_data_q;
  assign bus.ex_rs2_data   = rs2_data_q;
  assign bus.ex_imm        = imm_q;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_rs1        = rs1_q;
  assign bus.ex_rs2        = rs2_q;
  assign bus.ex_alu_op     = ctrl_q.alu_op;
  assign bus.ex_alu_src    = ctrl_q.alu_src;
  assign bus.ex_mem_read   = ctrl_q.mem_read;
  assign bus.ex_mem_write  = ctrl_q.mem_write;
  assign bus.ex_reg_write  = ctrl_q.reg_write;
  assign bus.ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign bus.ex_branch     = ctrl_q.branch;
  assign bus.ex_jump       = ctrl_q.jump;
  assign bus.ex_illegal    = ctrl_q.illegal;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d, flush_cnt_q, flush_cnt_d;
  always_comb begin
    bubble_cnt_d = bubble_cnt_q + {31'd0, ~bus.flush & ~bus.hold & hazard};
    flush_cnt_d  = flush_cnt_q + {31'd0, bus.flush};
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end
  assign perf_bubble_cnt = bubble_cnt_q;
  assign perf_flush_cnt  = flush_cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage (optionally with ID_EX_PERF_CNT_EN)
module tb_id_ex_stage;
  import rv_pipe_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int passed = 0;
  id_ex_stage_if #(.XLEN(32), .NREG_BITS(5)) bus ();
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_b, perf_f;
  id_ex_stage dut (.clock(clk), .reset(rst_n), .bus(bus), .perf_bubble_cnt(perf_b), .perf_flush_cnt(perf_f));
`else
  id_ex_stage dut (.clock(clk), .reset(rst_n), .bus(bus));
`endif
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] d1, input logic [31:0] d2);
    bus.if_id_valid = v;
    bus.if_id_pc = pc;
    bus.if_id_instr = ins;
    bus.rs1_data = d1;
    bus.rs2_data = d2;
  endtask
  task automatic test_reset;
    bus.flush = 1'b0;
    bus.hold = 1'b1;
    drive(1'b1, 32'h100, 32'h00708293, 32'h10, 32'h0);
    tick;
    tick;
    checks++; if (bus.stall_if !== 1'b0) $display("FAIL reset_stall got %b want 0", bus.stall_if); else passed++;
    checks++; if (bus.ex_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.ex_valid); else passed++;
    checks++; if (bus.ex_reg_write !== 1'b0) $display("FAIL reset_reg_write got %b want 0", bus.ex_reg_write); else passed++;
    checks++; if (bus.ex_imm !== 32'h0) $display("FAIL reset_imm got %h want 0", bus.ex_imm); else passed++;
    checks++; if (bus.ex_pc !== 32'h0) $display("FAIL reset_pc got %h want 0", bus.ex_pc); else passed++;
    bus.hold = 1'b0;
    rst_n = 1'b1;
  endtask
  task automatic test_addi;
    drive(1'b1, 32'h100, 32'h00708293, 32'h10, 32'h0);
    #1;
    checks++; if (bus.rs1_addr !== 5'd1) $display("FAIL addi_rs1_addr got %0d want 1", bus.rs1_addr); else passed++;
    tick;
    checks++; if (bus.ex_valid !== 1'b1) $display("FAIL addi_valid got %b want 1", bus.ex_valid); else passed++;
    checks++; if (bus.ex_imm !== 32'd7) $display("FAIL addi_imm got %h want 7", bus.ex_imm); else passed++;
    checks++; if (bus.ex_rd !== 5'd5) $display("FAIL addi_rd got %0d want 5", bus.ex_rd); else passed++;
    checks++; if (bus.ex_alu_src !== 1'b1) $display("FAIL addi_alu_src got %b want 1", bus.ex_alu_src); else passed++;
    checks++; if (bus.ex_reg_write !== 1'b1) $display("FAIL addi_reg_write got %b want 1", bus.ex_reg_write); else passed++;
    checks++; if (bus.ex_rs1_data !== 32'h10) $display("FAIL addi_rs1_data got %h want 10", bus.ex_rs1_data); else passed++;
    checks++; if (bus.ex_pc !== 32'h100) $display("FAIL addi_pc got %h want 100", bus.ex_pc); else passed++;
    checks++; if (bus.ex_alu_op !== ALU_ADD) $display("FAIL addi_alu_op got %0d want %0d", bus.ex_alu_op, ALU_ADD); else passed++;
  endtask
  task automatic test_load_use;
    drive(1'b1, 32'h104, 32'h00012303, 32'h2000, 32'h0);
    tick;
    checks++; if (bus.ex_mem_read !== 1'b1) $display("FAIL lw_mem_read got %b want 1", bus.ex_mem_read); else passed++;
    checks++; if (bus.ex_rd !== 5'd6) $display("FAIL lw_rd got %0d want 6", bus.ex_rd); else passed++;
    drive(1'b1, 32'h108, 32'h003303B3, 32'h55, 32'h3);
    #1;
    checks++; if (bus.stall_if !== 1'b1) $display("FAIL lu_stall got %b want 1", bus.stall_if); else passed++;
    tick;
    checks++; if (bus.ex_valid !== 1'b0) $display("FAIL lu_bubble_valid got %b want 0", bus.ex_valid); else passed++;
    checks++; if (bus.ex_mem_read !== 1'b0) $display("FAIL lu_bubble_mem_read got %b want 0", bus.ex_mem_read); else passed++;
    checks++; if (bus.stall_if !== 1'b0) $display("FAIL lu_stall_release got %b want 0", bus.stall_if); else passed++;
    tick;
    checks++; if (bus.ex_valid !== 1'b1) $display("FAIL lu_add_valid got %b want 1", bus.ex_valid); else passed++;
    checks++; if (bus.ex_rs1 !== 5'd6) $display("FAIL lu_add_rs1 got %0d want 6", bus.ex_rs1); else passed++;
    checks++; if (bus.ex_rs2 !== 5'd3) $display("FAIL lu_add_rs2 got %0d want 3", bus.ex_rs2); else passed++;
    checks++; if (bus.ex_pc !== 32'h108) $display("FAIL lu_add_pc got %h want 108", bus.ex_pc); else passed++;
    checks++; if (bus.ex_rs1_data !== 32'h55) $display("FAIL lu_add_rs1_data got %h want 55", bus.ex_rs1_data); else passed++;
    drive(1'b1, 32'h10C, 32'h40630433, 32'h55, 32'h55);
    #1;
    checks++; if (bus.stall_if !== 1'b0) $display("FAIL lu_second_dep_stall got %b want 0", bus.stall_if); else passed++;
    tick;
    checks++; if (bus.ex_alu_op !== ALU_SUB) $display("FAIL sub_alu_op got %0d want %0d", bus.ex_alu_op, ALU_SUB); else passed++;
    checks++; if (bus.ex_rd !== 5'd8) $display("FAIL sub_rd got %0d want 8", bus.ex_rd); else passed++;
  endtask
  task automatic test_x0;
    drive(1'b1, 32'h110, 32'h00012003, 32'h2000, 32'h0);
    tick;
    checks++; if (bus.ex_mem_read !== 1'b1) $display("FAIL x0_lw_mem_read got %b want 1", bus.ex_mem_read); else passed++;
    checks++; if (bus.ex_reg_write !== 1'b0) $display("FAIL x0_lw_reg_write got %b want 0", bus.ex_reg_write); else passed++;
    checks++; if (bus.ex_rd !== 5'd0) $display("FAIL x0_lw_rd got %0d want 0", bus.ex_rd); else passed++;
    drive(1'b1, 32'h114, 32'h003003B3, 32'h0, 32'h3);
    #1;
    checks++; if (bus.stall_if !== 1'b0) $display("FAIL x0_stall got %b want 0", bus.stall_if); else passed++;
    tick;
    checks++; if (bus.ex_valid !== 1'b1) $display("FAIL x0_add_valid got %b want 1", bus.ex_valid); else passed++;
    checks++; if (bus.ex_rd !== 5'd7) $display("FAIL x0_add_rd got %0d want 7", bus.ex_rd); else passed++;
  endtask
  task automatic test_imm_types;
    drive(1'b1, 32'h118, 32'hFE000CE3, 32'h0, 32'h0);
    tick;
    checks++; if (bus.ex_imm !== 32'hFFFFFFF8) $display("FAIL beq_imm got %h want fffffff8", bus.ex_imm); else passed++;
    checks++; if (bus.ex_branch !== 1'b1) $display("FAIL beq_branch got %b want 1", bus.ex_branch); else passed++;
    checks++; if (bus.ex_reg_write !== 1'b0) $display("FAIL beq_reg_write got %b want 0", bus.ex_reg_write); else passed++;
    checks++; if (bus.ex_alu_src !== 1'b0) $display("FAIL beq_alu_src got %b want 0", bus.ex_alu_src); else passed++;
    drive(1'b1, 32'h11C, 32'hFE512E23, 32'h0, 32'h0);
    tick;
    checks++; if (bus.ex_imm !== 32'hFFFFFFFC) $display("FAIL sw_imm got %h want fffffffc", bus.ex_imm); else passed++;
    checks++; if (bus.ex_mem_write !== 1'b1) $display("FAIL sw_mem_write got %b want 1", bus.ex_mem_write); else passed++;
    drive(1'b1, 32'h120, 32'h123451B7, 32'h0, 32'h0);
    tick;
    checks++; if (bus.ex_imm !== 32'h12345000) $display("FAIL lui_imm got %h want 12345000", bus.ex_imm); else passed++;
    checks++; if (bus.ex_alu_op !== ALU_PASS_B) $display("FAIL lui_alu_op got %0d want %0d", bus.ex_alu_op, ALU_PASS_B); else passed++;
    checks++; if (bus.ex_jump !== 1'b0) $display("FAIL lui_jump got %b want 0", bus.ex_jump); else passed++;
  endtask
  task automatic test_hold;
    drive(1'b1, 32'h124, 32'h00708293, 32'h10, 32'h0);
    tick;
    bus.hold = 1'b1;
    drive(1'b1, 32'h128, 32'h123451B7, 32'h0, 32'h0);
    #1;
    checks++; if (bus.stall_if !== 1'b1) $display("FAIL hold_stall got %b want 1", bus.stall_if); else passed++;
    tick;
    checks++; if (bus.ex_imm !== 32'd7) $display("FAIL hold_imm got %h want 7", bus.ex_imm); else passed++;
    checks++; if (bus.ex_pc !== 32'h124) $display("FAIL hold_pc got %h want 124", bus.ex_pc); else passed++;
    checks++; if (bus.ex_valid !== 1'b1) $display("FAIL hold_valid got %b want 1", bus.ex_valid); else passed++;
  endtask
  task automatic test_flush_hold;
    bus.flush = 1'b1;
    bus.hold = 1'b1;
    #1;
    checks++; if (bus.stall_if !== 1'b0) $display("FAIL flush_stall got %b want 0", bus.stall_if); else passed++;
    tick;
    checks++; if (bus.ex_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", bus.ex_valid); else passed++;
    checks++; if (bus.ex_reg_write !== 1'b0) $display("FAIL flush_reg_write got %b want 0", bus.ex_reg_write); else passed++;
    bus.flush = 1'b0;
    bus.hold = 1'b0;
  endtask
  task automatic test_invalid_and_illegal;
    drive(1'b0, 32'h12C, 32'h00708293, 32'h10, 32'h0);
    tick;
    checks++; if (bus.ex_valid !== 1'b0) $display("FAIL inv_valid got %b want 0", bus.ex_valid); else passed++;
    checks++; if (bus.ex_reg_write !== 1'b0) $display("FAIL inv_reg_write got %b want 0", bus.ex_reg_write); else passed++;
    drive(1'b1, 32'h130, 32'h0000037F, 32'h0, 32'h0);
    tick;
    checks++; if (bus.ex_illegal !== 1'b1) $display("FAIL ill_flag got %b want 1", bus.ex_illegal); else passed++;
    checks++; if (bus.ex_valid !== 1'b1) $display("FAIL ill_valid got %b want 1", bus.ex_valid); else passed++;
    checks++; if (bus.ex_mem_write !== 1'b0) $display("FAIL ill_mem_write got %b want 0", bus.ex_mem_write); else passed++;
    checks++; if (bus.ex_reg_write !== 1'b0) $display("FAIL ill_reg_write got %b want 0", bus.ex_reg_write); else passed++;
    checks++; if (bus.ex_mem_read !== 1'b0) $display("FAIL ill_mem_read got %b want 0", bus.ex_mem_read); else passed++;
    drive(1'b1, 32'h134, 32'h00708293, 32'h10, 32'h0);
    tick;
    checks++; if (bus.ex_illegal !== 1'b0) $display("FAIL ill_clear got %b want 0", bus.ex_illegal); else passed++;
  endtask
`ifdef ID_EX_PERF_CNT_EN
  task automatic test_perf;
    bus.flush = 1'b1;
    tick;
    tick;
    bus.flush = 1'b0;
    checks++; if (perf_f !== 32'd3) $display("FAIL perf_flush got %0d want 3", perf_f); else passed++;
    checks++; if (perf_b !== 32'd1) $display("FAIL perf_bubble got %0d want 1", perf_b); else passed++;
  endtask
`endif
  initial begin
    test_reset;
    test_addi;
    test_load_use;
    test_x0;
    test_imm_types;
    test_hold;
    test_flush_hold;
    test_invalid_and_illegal;
`ifdef ID_EX_PERF_CNT_EN
    test_perf;
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode stage back half plus ID/EX pipeline register of the 5-stage RV32I pipeline.
- Takes the IF/ID instruction and drives rs1/rs2 addresses to the register file.
- Samples the register-file read data, generates the immediate and control bundle, and registers them for EX.
- Detects load-use hazards and owns bubble insertion, flush and hold of the ID/EX register.

Parameters:
XLEN, 32, datapath width (pc, operands, immediate)
NREG_BITS, 5, register address width

Ports:
clock  in  1  pipeline clock; all state updates on posedge
reset  in  1  synchronous, active-low reset
if_id_valid  in  1  IF/ID holds a real instruction
if_id_pc  in  XLEN  PC of IF/ID instruction
if_id_instr  in  32  IF/ID instruction word
rs1_addr  out  NREG_BITS  combinational instr[19:15] to register file
rs2_addr  out  NREG_BITS  combinational instr[24:20] to register file
rs1_data  in  XLEN  register file read data for rs1_addr (valid by posedge)
rs2_data  in  XLEN  register file read data for rs2_addr
flush  in  1  branch/jump redirect from EX; kill ID instruction
hold  in  1  downstream stall; freeze ID/EX register
stall_if  out  1  combinational; freeze PC and IF/ID this cycle
ex_valid  out  1  ID/EX holds a real instruction
ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each  registered operands
ex_rd, ex_rs1, ex_rs2  out  NREG_BITS each  registered register indices (for forwarding)
ex_alu_op  out  4  registered ALU operation (package enum)
ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch, ex_jump  out  1 each  registered control
ex_illegal  out  1  registered unknown-opcode flag

Behaviour:
- Reset (reset==0 at posedge): every registered output is 0, including ex_valid and all control bits. stall_if is held 0 while reset is low.
- Decode covers opcodes R 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
- Immediate types I/S/B/U/J are sign-extended to XLEN. The B and J immediates have bit 0 = 0.
- Any other opcode sets ex_illegal=1, ex_valid=1 and all write/mem control bits 0.
- Operand usage:
  - rs1 is used by all opcodes except LUI, AUIPC and JAL.
  - rs2 is used by R, STORE and BRANCH.
- Load-use hazard: ex_valid & ex_mem_read & ex_rd!=0 & if_id_valid & ((rs1 used & ex_rd==rs1_addr) | (rs2 used & ex_rd==rs2_addr)).
- Per-posedge priority, highest first:
  1. reset: clear all registered outputs.
  2. flush: ex_valid<=0 and all control bits <=0; stall_if=0 this cycle.
  3. hold: all ex_* keep their value; stall_if=1.
  4. load-use hazard: insert bubble (ex_valid<=0, control <=0, data fields don't-care); stall_if=1.
  5. normal: capture decode of IF/ID, with ex_valid<=if_id_valid. If if_id_valid==0, control bits are forced to 0.
- Bubble length is exactly one cycle. The bubble clears ex_mem_read, so the hazard self-resolves on the next cycle.
- A load followed by two dependent instructions yields one bubble only.
- Latency: IF/ID to ex_* is one cycle, absent stall/flush.
- x0 never raises a hazard. A destination rd of 0 is captured as is; ex_reg_write is forced 0 when rd==0.
- flush and hold asserted together: flush wins.
- ex_jump=1 for JAL and JALR. ex_alu_src=1 selects ex_imm for every opcode except R and BRANCH.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- When defined, two outputs are added:
  - perf_bubble_cnt (32): increments on each load-use bubble insertion.
  - perf_flush_cnt (32): increments on each posedge with flush=1 and reset=1.
  - Both clear on reset and wrap at 2^32-1 -> 0.
- When undefined, the ports and counters are absent and the remaining behaviour is identical.

Decomposition:
- Package rv_pipe_pkg holds:
  - opcode localparams;
  - the alu_op enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B);
  - the imm_type enum;
  - the control-bundle struct.
- One sub-module, rv_imm_gen: purely combinational instruction + imm_type -> XLEN immediate.

Test Plan:
- Reset, then ADDI x5,x1,7 (0x00708293) with rs1_data=0x10 -> next cycle ex_valid=1, ex_imm=7, ex_rd=5, ex_alu_src=1, ex_reg_write=1.
- LW x6,0(x2) then ADD x7,x6,x3 -> stall_if=1 for one cycle, one ex_valid=0 bubble, then ADD captured with ex_rs1=6.
- LW x0,0(x2) then ADD x7,x0,x3 -> no stall, no bubble.
- BEQ with imm -8 (0xFE000CE3) -> ex_imm=0xFFFFFFF8, ex_branch=1, ex_reg_write=0.
- flush=1 and hold=1 in the same cycle -> ex_valid=0 next cycle, stall_if=0.
- Opcode 0x7F -> ex_illegal=1, ex_mem_write=0, ex_reg_write=0. With ID_EX_PERF_CNT_EN defined, 3 flushes -> perf_flush_cnt=3.
